// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard and forwarding controller for the in-order
// integer pipeline.
//
// Tracks in-flight destinations through a DEPTH-entry shift register covering
// the post-ID stages (entry 1 = EX ... entry DEPTH = WB). For the instruction
// sitting in ID it produces the load-use stall, the registered EX forwarding
// selects, and the flushes for a redirect resolved in EX.
//
// Optional feature macro: PHC_PERF_CNT_EN
//   When defined, stall_cnt / flush_cnt count stall cycles and redirect cycles,
//   saturating at all-ones. When undefined, both outputs are tied to zero.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   id_valid                ID holds a real instruction
//   id_rs/id_rt             source registers, id_rs_used/id_rt_used qualify them
//   id_rd/id_we/id_is_load  destination, write enable, load flag of ID instr
//   ex_redirect             taken branch/jump resolved in EX this cycle
//   stall                   hold PC and IF/ID, bubble into EX (combinational)
//   flush_ifid, flush_idex  squash IF/ID and ID/EX (combinational)
//   ex_fwd_a, ex_fwd_b      registered EX operand selects: 0 = RF, k = stage k
//   wb_we, wb_rd            entry DEPTH write enable and destination
//   stall_cnt, flush_cnt    performance counters (PHC_PERF_CNT_EN only)

// Per-source producer search. Finds the youngest in-flight writer of src
// among entries 1..DEPTH-1 and reports the forward select and whether the
// result is not yet ready for the consumer's EX cycle.
module phc_src_fwd #(
  parameter int RA_W       = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3,
  parameter int SEL_W      = 2
) (
  input  logic [RA_W-1:0]              src,
  input  logic                         used,
  input  logic [DEPTH-1:1]             vld,
  input  logic [DEPTH-1:1]             we,
  input  logic [DEPTH-1:1]             ld,
  input  logic [DEPTH-1:1][RA_W-1:0]   rd,
  output logic [SEL_W-1:0]             sel,
  output logic                         haz
);

  // Scan oldest to youngest so the smallest matching k is the last writer.
  // Entry DEPTH is excluded: the register file is write-through, so ID
  // already reads the value being written back.
  always_comb begin
    sel = '0;
    haz = 1'b0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (used && vld[k] && we[k] && (rd[k] == src) && (src != '0)) begin
        // By the time the consumer reaches EX the producer sits at k+1.
        sel = SEL_W'(k + 1);
        haz = (k + 1) < (ld[k] ? LOAD_READY : ALU_READY);
      end
    end
  end

endmodule

module pipe_hazard_ctrl #(
  parameter int RA_W       = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 3,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [SEL_W-1:0]  ex_fwd_a,
  output logic [SEL_W-1:0]  ex_fwd_b,
  output logic              wb_we,
  output logic [RA_W-1:0]   wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int NUM_SRC = 2;

  // In-flight entries. The load flag is only needed where a match can occur,
  // so it stops at DEPTH-1.
  logic [DEPTH:1]             vld_pipe;
  logic [DEPTH:1]             we_pipe;
  logic [DEPTH:1][RA_W-1:0]   rd_pipe;
  logic [DEPTH-1:1]           ld_pipe;

  logic [NUM_SRC-1:0][RA_W-1:0]  src;
  logic [NUM_SRC-1:0]            used;
  logic [NUM_SRC-1:0][SEL_W-1:0] sel;
  logic [NUM_SRC-1:0]            haz;
  logic                          issue;

  assign src  = {id_rt, id_rs};
  assign used = {id_rt_used, id_rs_used};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    phc_src_fwd #(
      .RA_W      (RA_W),
      .DEPTH     (DEPTH),
      .ALU_READY (ALU_READY),
      .LOAD_READY(LOAD_READY),
      .SEL_W     (SEL_W)
    ) u_fwd (
      .src (src[s]),
      .used(used[s]),
      .vld (vld_pipe[DEPTH-1:1]),
      .we  (we_pipe[DEPTH-1:1]),
      .ld  (ld_pipe),
      .rd  (rd_pipe[DEPTH-1:1]),
      .sel (sel[s]),
      .haz (haz[s])
    );
  end

  // Redirect beats a pending stall: the stalled ID instruction is on the
  // wrong path and gets flushed instead of held.
  assign stall      = ~reset & id_valid & ~ex_redirect & (|haz);
  assign flush_ifid = ~reset & ex_redirect;
  assign flush_idex = ~reset & ex_redirect;
  assign issue      = id_valid & ~stall & ~ex_redirect;

  assign wb_we = vld_pipe[DEPTH] & we_pipe[DEPTH];
  assign wb_rd = rd_pipe[DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      we_pipe  <= '0;
      rd_pipe  <= '0;
      ld_pipe  <= '0;
      ex_fwd_a <= '0;
      ex_fwd_b <= '0;
    end else begin
      // Bubbles carry zeroed fields so downstream entries stay clean.
      vld_pipe[1] <= issue;
      we_pipe[1]  <= issue & id_we;
      rd_pipe[1]  <= issue ? id_rd : '0;
      ld_pipe[1]  <= issue & id_is_load;
      for (int k = 2; k <= DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        we_pipe[k]  <= we_pipe[k-1];
        rd_pipe[k]  <= rd_pipe[k-1];
      end
      for (int k = 2; k <= DEPTH - 1; k++) begin
        ld_pipe[k] <= ld_pipe[k-1];
      end
      ex_fwd_a <= issue ? sel[0] : '0;
      ex_fwd_b <= issue ? sel[1] : '0;
    end
  end

`ifdef PHC_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_redirect && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default 3-stage, and a 5-stage
// with ALU_READY=3 / LOAD_READY=5) share one stimulus stream. A history model
// tracks each issued instruction by its age and derives every output from the
// hazard rules; directed scenarios pin literal values.
module tb_pipe_hazard_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       id_valid, id_rs_used, id_rt_used, id_we, id_is_load, ex_redirect;
  logic [4:0] id_rs, id_rt, id_rd;

  logic        stl [2];
  logic        fif [2];
  logic        fdx [2];
  logic        wbw [2];
  logic [4:0]  wbr [2];
  logic [15:0] sc  [2];
  logic [15:0] fc  [2];
  logic [1:0]  fa0, fb0;
  logic [2:0]  fa1, fb1;
  logic [2:0]  fa  [2];
  logic [2:0]  fb  [2];

  assign fa[0] = {1'b0, fa0};
  assign fb[0] = {1'b0, fb0};
  assign fa[1] = fa1;
  assign fb[1] = fb1;

  pipe_hazard_ctrl u_d0 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall(stl[0]),
    .flush_ifid(fif[0]), .flush_idex(fdx[0]), .ex_fwd_a(fa0), .ex_fwd_b(fb0),
    .wb_we(wbw[0]), .wb_rd(wbr[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0]));

  pipe_hazard_ctrl #(.DEPTH(5), .ALU_READY(3), .LOAD_READY(5), .SEL_W(3)) u_d1 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall(stl[1]),
    .flush_ifid(fif[1]), .flush_idex(fdx[1]), .ex_fwd_a(fa1), .ex_fwd_b(fb1),
    .wb_we(wbw[1]), .wb_rd(wbr[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1]));

  // ---------------- reference model ----------------
  typedef struct {
    int rd;
    bit we;
    bit ld;
    int age;   // 1 = in EX this cycle
  } ent_t;

  ent_t h [2][$];
  int   dep_p [2] = '{3, 5};
  int   alu_p [2] = '{2, 3};
  int   ldr_p [2] = '{3, 5};
  int   efa [2], efb [2], esc [2], efc [2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Youngest qualifying producer for one source; returns select and hazard.
  function automatic void find_src(input int u, input int s, input bit s_used,
                                   output int sel, output bit hz);
    int best_age = 0;
    bit best_ld  = 1'b0;
    sel = 0;
    hz  = 1'b0;
    if (!s_used || s == 0) return;
    foreach (h[u][i]) begin
      if (h[u][i].we && h[u][i].rd == s && h[u][i].age <= dep_p[u] - 1 &&
          (best_age == 0 || h[u][i].age < best_age)) begin
        best_age = h[u][i].age;
        best_ld  = h[u][i].ld;
      end
    end
    if (best_age != 0) begin
      sel = best_age + 1;
      hz  = (best_age + 1) < (best_ld ? ldr_p[u] : alu_p[u]);
    end
  endfunction

  // Compare all outputs of both DUTs against the model, then advance one edge.
  task automatic cycle();
    int sa [2];
    int sb [2];
    bit st [2];
    #1;
    for (int u = 0; u < 2; u++) begin
      bit ha, hb, ewe;
      int erd;
      string p;
      p = (u == 0) ? "d0" : "d1";
      find_src(u, int'(id_rs), id_rs_used, sa[u], ha);
      find_src(u, int'(id_rt), id_rt_used, sb[u], hb);
      st[u] = id_valid && !ex_redirect && !reset && (ha || hb);
      ewe = 1'b0;
      erd = 0;
      foreach (h[u][i]) if (h[u][i].age == dep_p[u]) begin
        ewe = h[u][i].we;
        erd = h[u][i].rd;
      end
      chk({p, "_stall"},      32'(stl[u]), 32'(st[u]));
      chk({p, "_flush_ifid"}, 32'(fif[u]), 32'(ex_redirect && !reset));
      chk({p, "_flush_idex"}, 32'(fdx[u]), 32'(ex_redirect && !reset));
      chk({p, "_ex_fwd_a"},   32'(fa[u]),  32'(efa[u]));
      chk({p, "_ex_fwd_b"},   32'(fb[u]),  32'(efb[u]));
      chk({p, "_wb_we"},      32'(wbw[u]), 32'(ewe));
      if (ewe) chk({p, "_wb_rd"}, 32'(wbr[u]), 32'(erd));
      chk({p, "_stall_cnt"},  32'(sc[u]),  32'(esc[u]));
      chk({p, "_flush_cnt"},  32'(fc[u]),  32'(efc[u]));
    end
    @(posedge clock);
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        h[u].delete();
        efa[u] = 0; efb[u] = 0; esc[u] = 0; efc[u] = 0;
      end else begin
        ent_t nq [$];
        bit   ld_now;
        ld_now = id_valid && !st[u] && !ex_redirect;
        efa[u] = ld_now ? sa[u] : 0;
        efb[u] = ld_now ? sb[u] : 0;
`ifdef PHC_PERF_CNT_EN
        if (st[u] && esc[u] < 65535) esc[u]++;
        if (ex_redirect && efc[u] < 65535) efc[u]++;
`endif
        foreach (h[u][i]) if (h[u][i].age < dep_p[u]) begin
          ent_t e;
          e = h[u][i];
          e.age++;
          nq.push_back(e);
        end
        if (ld_now) nq.push_back('{rd: int'(id_rd), we: id_we, ld: id_is_load, age: 1});
        h[u] = nq;
      end
    end
    @(negedge clock);
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                       input int rd, input bit we, input bit ld);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rs_used = rsu; id_rt_used = rtu;
    id_rd = 5'(rd); id_we = we; id_is_load = ld;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

`ifdef PHC_PERF_CNT_EN
  localparam int FC_ONE = 1;
`else
  localparam int FC_ONE = 0;
`endif

  initial begin
    reset = 1'b1;
    ex_redirect = 1'b0;
    drive(1, 1, 2, 1, 1, 3, 1, 1);
    @(posedge clock);
    @(negedge clock);
    // Reset holds combinational outputs low even with a redirect present.
    ex_redirect = 1'b1;
    #1;
    chk("rst_stall", 32'(stl[0]), 32'(0));
    chk("rst_flush", 32'(fif[0]), 32'(0));
    cycle();
    ex_redirect = 1'b0;
    cycle();
    chk("rst_wb_we", 32'(wbw[0]), 32'(0));
    chk("rst_wb_rd", 32'(wbr[1]), 32'(0));
    chk("rst_fwd_a", 32'(fa[0]), 32'(0));
    reset = 1'b0;
    idle(2);

    // ALU -> dependent ALU: forward from stage 2, no stall.
    drive(1, 1, 2, 1, 1, 3, 1, 0); cycle();
    drive(1, 3, 0, 1, 0, 8, 1, 0);
    #1 chk("alu_use_stall", 32'(stl[0]), 32'(0));
    cycle();
    chk("alu_use_fwd_a", 32'(fa[0]), 32'(2));
    idle(6);

    // Load -> use: one stall cycle, EX bubble, then forward from stage 3.
    drive(1, 1, 0, 1, 0, 4, 1, 1); cycle();
    drive(1, 0, 4, 0, 1, 9, 1, 0);
    #1 chk("ld_use_stall1", 32'(stl[0]), 32'(1));
    cycle();
    chk("ld_use_bubble", 32'(fb[0]), 32'(0));
    #1 chk("ld_use_stall2", 32'(stl[0]), 32'(0));
    cycle();
    chk("ld_use_fwd_b", 32'(fb[0]), 32'(3));
    idle(6);

    // r0 never creates a hazard.
    drive(1, 1, 2, 1, 1, 0, 1, 0); cycle();
    drive(1, 0, 0, 1, 1, 9, 1, 0);
    #1 chk("r0_stall", 32'(stl[0]), 32'(0));
    cycle();
    chk("r0_fwd_a", 32'(fa[0]), 32'(0));
    idle(6);

    // Youngest producer wins.
    drive(1, 1, 2, 1, 1, 5, 1, 0); cycle();
    drive(1, 1, 2, 1, 1, 5, 1, 0); cycle();
    drive(1, 5, 0, 1, 0, 9, 1, 0); cycle();
    chk("youngest_fwd_a", 32'(fa[0]), 32'(2));
    idle(6);

    // Redirect during a load-use stall: flush wins, counters reflect it.
    reset = 1'b1; cycle(); reset = 1'b0;
    drive(1, 1, 0, 1, 0, 6, 1, 1); cycle();
    drive(1, 6, 0, 1, 0, 9, 1, 0);
    #1 chk("redir_pre_stall", 32'(stl[0]), 32'(1));
    ex_redirect = 1'b1;
    #1;
    chk("redir_stall", 32'(stl[0]), 32'(0));
    chk("redir_flush_ifid", 32'(fif[0]), 32'(1));
    chk("redir_flush_idex", 32'(fdx[0]), 32'(1));
    cycle();
    ex_redirect = 1'b0;
    chk("redir_bubble_a", 32'(fa[0]), 32'(0));
    chk("redir_flush_cnt", 32'(fc[0]), 32'(FC_ONE));
    chk("redir_stall_cnt", 32'(sc[0]), 32'(0));
    idle(6);

    // 5-stage instance: load-use costs three stalls, then select 5.
    drive(1, 1, 0, 1, 0, 7, 1, 1); cycle();
    drive(1, 7, 0, 1, 0, 9, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("d5_ld_stall", 32'(stl[1]), 32'(1));
      cycle();
    end
    #1 chk("d5_ld_release", 32'(stl[1]), 32'(0));
    cycle();
    chk("d5_fwd_a", 32'(fa[1]), 32'(5));
    idle(7);

    // Reset mid-stall discards everything in flight.
    drive(1, 1, 0, 1, 0, 7, 1, 1); cycle();
    drive(1, 7, 0, 1, 0, 9, 1, 0);
    #1 chk("d5_pre_rst_stall", 32'(stl[1]), 32'(1));
    reset = 1'b1; cycle(); reset = 1'b0;
    #1;
    chk("d5_post_rst_stall", 32'(stl[1]), 32'(0));
    chk("d5_post_rst_wb_we", 32'(wbw[1]), 32'(0));
    idle(6);

    // Randomised traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
